// File: rtl/hwpe_stream_tcdm_load_buffer.sv
// -----------------------------------------------------------------------------
// hwpe_stream_tcdm_load_buffer
//
// Per-channel TCDM decoupling stage sitting between a streamer-side master and
// one input port of the TCDM multiplexer. Requests are forwarded unchanged;
// read responses (fixed one-cycle TCDM latency) are captured into a small
// local FIFO that the consumer drains with valid/ready. Reads are only issued
// while a free FIFO slot is guaranteed, so the FIFO can never overflow even
// when the consumer applies backpressure.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   clear_i              synchronous soft clear (same effect as reset)
//   in_*                 upstream TCDM request (req/add/wen/be/data, gnt back)
//   out_*                request to the mux (req/add/wen/be/data, gnt in)
//   out_r_data_i/valid_i TCDM read response from the mux
//   resp_valid_o/data_o  FIFO head towards the consumer
//   resp_ready_i         consumer pop
//   credits_o            free read credits (FIFO slots not yet claimed)
//   err_o                sticky flag: response arrived with no read pending
// -----------------------------------------------------------------------------
module hwpe_stream_tcdm_load_buffer #(
    parameter int unsigned FIFO_DEPTH = 4,  // power of 2, >= 2
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,

    input  logic                            in_req_i,
    input  logic [ADDR_WIDTH-1:0]           in_add_i,
    input  logic                            in_wen_i,
    input  logic [DATA_WIDTH/8-1:0]         in_be_i,
    input  logic [DATA_WIDTH-1:0]           in_data_i,
    output logic                            in_gnt_o,

    output logic                            out_req_o,
    output logic [ADDR_WIDTH-1:0]           out_add_o,
    output logic                            out_wen_o,
    output logic [DATA_WIDTH/8-1:0]         out_be_o,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    input  logic                            out_gnt_i,
    input  logic [DATA_WIDTH-1:0]           out_r_data_i,
    input  logic                            out_r_valid_i,

    output logic                            resp_valid_o,
    output logic [DATA_WIDTH-1:0]           resp_data_o,
    input  logic                            resp_ready_i,

    output logic [$clog2(FIFO_DEPTH):0]     credits_o,
    output logic                            err_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_pending;   // one read granted last cycle, response due now
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [CNT_W-1:0]      w_credits;
    logic                  w_has_credit;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_spurious;
    logic [CNT_W-1:0]      w_count_nxt;

    // -------------------------------------------------------------------------
    // Credits: derived from registered state only, so a pop in this cycle
    // frees its slot next cycle and resp_ready_i never reaches out_req_o.
    // -------------------------------------------------------------------------
    assign w_credits    = CNT_W'(FIFO_DEPTH) - r_count - CNT_W'(r_pending);
    assign w_has_credit = (w_credits != '0);
    assign credits_o    = w_credits;

    // -------------------------------------------------------------------------
    // Request path. Writes bypass the credit check; nothing is issued while
    // reset or clear is active, so no response can be in flight afterwards.
    // -------------------------------------------------------------------------
    assign out_add_o  = in_add_i;
    assign out_wen_o  = in_wen_i;
    assign out_be_o   = in_be_i;
    assign out_data_o = in_data_i;

    assign out_req_o  = in_req_i & rst_ni & ~clear_i & (~in_wen_i | w_has_credit);
    assign in_gnt_o   = out_req_o & out_gnt_i;

    // -------------------------------------------------------------------------
    // Response FIFO control
    // -------------------------------------------------------------------------
    assign resp_valid_o = (r_count != '0);
    assign resp_data_o  = r_mem[r_rd_ptr];

    assign w_push     = out_r_valid_i &  r_pending & ~clear_i;
    assign w_spurious = out_r_valid_i & ~r_pending & ~clear_i;
    assign w_pop      = resp_valid_o & resp_ready_i;

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_pending <= in_gnt_o & in_wen_i;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);  // wraps: depth is a power of 2
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; entries are only observable once
    // written, because resp_valid_o is driven by the reset count.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_push) begin
            r_mem[r_wr_ptr] <= out_r_data_i;
        end
    end

    assign err_o = r_err;

endmodule
